// File: rtl/gpio_serial_cfg_loader_if.sv
// Bundles the start/busy/done handshake, the config read port and the serial pad-chain signals.
interface gpio_serial_cfg_loader_if #(
   parameter int NUM_IO   = 38,
   parameter int CFG_BITS = 13
);
   localparam int IDX_W = $clog2(NUM_IO);

   logic                start;
   logic [IDX_W-1:0]    cfg_rd_idx;
   logic [CFG_BITS-1:0] cfg_rd_data;
   logic                busy;
   logic                done;
   logic                serial_clock;
   logic                serial_data_out;
   logic                serial_load;

   modport master (
      input  start, cfg_rd_data,
      output cfg_rd_idx, busy, done, serial_clock, serial_data_out, serial_load
   );

   modport slave (
      output start, cfg_rd_data,
      input  cfg_rd_idx, busy, done, serial_clock, serial_data_out, serial_load
   );
endinterface

// File: rtl/gpio_serial_cfg_loader.sv
// Shifts every pad's config word into the GPIO control daisy chain, last pad first,
// then pulses serial_load so the chain latches the new modes.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | read config word for pad idx
// SETUP | serial_clock low, data settling
// HIGH  | serial_clock high, chain samples on entry
// LOAD  | serial_load strobe
// DONE  | one-cycle completion pulse
module gpio_serial_cfg_loader #(
   parameter int NUM_IO   = 38,
   parameter int CFG_BITS = 13,
   parameter int CLK_DIV  = 4
) (
   input logic                     clock,
   input logic                     reset,
   gpio_serial_cfg_loader_if.master bus
);
   localparam int IDX_W = $clog2(NUM_IO);
   localparam int BIT_W = $clog2(CFG_BITS);
   localparam int DIV_W = $clog2(CLK_DIV + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_SETUP = 3'd2;
   localparam logic [2:0] S_HIGH  = 3'd3;
   localparam logic [2:0] S_LOAD  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]          state, state_nxt;
   logic [IDX_W-1:0]    idx;
   logic [BIT_W-1:0]    bitcnt;
   logic [DIV_W-1:0]    divcnt;
   logic [CFG_BITS-1:0] shreg;
   logic                div_tc;
   logic                busy_q, done_q, sclk_q, sdo_q, sload_q;

   assign div_tc = (divcnt == '0);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start) state_nxt = S_FETCH;
         S_FETCH: state_nxt = S_SETUP;
         S_SETUP: if (div_tc) state_nxt = S_HIGH;
         S_HIGH: begin
            if (div_tc) begin
               if (bitcnt != '0)   state_nxt = S_SETUP;
               else if (idx != '0) state_nxt = S_FETCH;
               else                state_nxt = S_LOAD;
            end
         end
         S_LOAD:  if (div_tc) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so each is a clean flop aligned to its state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         idx     <= '0;
         bitcnt  <= '0;
         divcnt  <= '0;
         shreg   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sclk_q  <= 1'b0;
         sdo_q   <= 1'b0;
         sload_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         busy_q  <= (state_nxt == S_FETCH) || (state_nxt == S_SETUP) ||
                    (state_nxt == S_HIGH)  || (state_nxt == S_LOAD);
         done_q  <= (state_nxt == S_DONE);
         sclk_q  <= (state_nxt == S_HIGH);
         sload_q <= (state_nxt == S_LOAD);

         if (state_nxt != state)  divcnt <= DIV_W'(CLK_DIV - 1);
         else if (divcnt != '0)   divcnt <= divcnt - 1'b1;

         case (state)
            S_IDLE: if (bus.start) idx <= IDX_W'(NUM_IO - 1);
            S_FETCH: begin
               shreg  <= bus.cfg_rd_data;
               bitcnt <= BIT_W'(CFG_BITS - 1);
               sdo_q  <= bus.cfg_rd_data[CFG_BITS-1];
            end
            S_HIGH: begin
               if (div_tc) begin
                  if (bitcnt != '0) begin
                     shreg  <= shreg << 1;
                     bitcnt <= bitcnt - 1'b1;
                     sdo_q  <= shreg[CFG_BITS-2];
                  end else if (idx != '0) begin
                     idx <= idx - 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.cfg_rd_idx      = idx;
   assign bus.busy            = busy_q;
   assign bus.done            = done_q;
   assign bus.serial_clock    = sclk_q;
   assign bus.serial_data_out = sdo_q;
   assign bus.serial_load     = sload_q;
endmodule

// File: tb/tb_gpio_serial_cfg_loader.sv
// Directed bench: default-size loader driving a pad-chain model, plus a tiny 2-pad instance.
module tb_gpio_serial_cfg_loader;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   gpio_serial_cfg_loader_if #(.NUM_IO(38), .CFG_BITS(13)) bus_a ();
   gpio_serial_cfg_loader_if #(.NUM_IO(2),  .CFG_BITS(3))  bus_b ();

   gpio_serial_cfg_loader #(.NUM_IO(38), .CFG_BITS(13), .CLK_DIV(4)) dut_a (
      .clock(clock), .reset(reset), .bus(bus_a));
   gpio_serial_cfg_loader #(.NUM_IO(2), .CFG_BITS(3), .CLK_DIV(1)) dut_b (
      .clock(clock), .reset(reset), .bus(bus_b));

   logic [12:0] cfg_a [0:63];
   logic [2:0]  cfg_b [0:1];
   assign bus_a.cfg_rd_data = cfg_a[bus_a.cfg_rd_idx];
   assign bus_b.cfg_rd_data = cfg_b[bus_b.cfg_rd_idx];

   // pad chain: bits enter at the head (bit 0); pad i ends up in [i*13 +: 13]
   logic [38*13-1:0] chain_a = '0, pad_a = '0, snap_a;
   int rise_a = 0;
   always @(posedge bus_a.serial_clock) begin
      chain_a <= {chain_a[38*13-2:0], bus_a.serial_data_out};
      rise_a++;
   end
   always @(posedge bus_a.serial_load) pad_a <= chain_a;

   logic [5:0] rec_b = '0;
   int rise_b = 0, load_cyc_b = 0;
   always @(posedge bus_b.serial_clock) begin
      rec_b <= {rec_b[4:0], bus_b.serial_data_out};
      rise_b++;
   end
   always @(negedge clock) if (bus_b.serial_load) load_cyc_b++;

   // waveform monitor for the default instance
   int hi_len = 0, lo_len = 0, mrise = 0, wave_err = 0, load_len = 0, load_cnt = 0;
   logic prev_sclk = 1'b0, prev_sdo = 1'b0;
   always @(negedge clock) begin
      if (reset || !bus_a.busy) begin
         hi_len = 0; lo_len = 0; mrise = 0;
      end else if (bus_a.serial_clock) begin
         if (bus_a.serial_data_out !== prev_sdo) wave_err++;
         if (!prev_sclk) begin
            if (lo_len != (((mrise % 13) == 0) ? 5 : 4)) wave_err++;
            mrise++;
            hi_len = 1;
         end else hi_len++;
      end else begin
         if (prev_sclk) begin
            if (hi_len != 4) wave_err++;
            lo_len = 1;
         end else lo_len++;
      end
      if (bus_a.serial_load) begin
         load_len++;
         if (bus_a.serial_clock || !bus_a.busy) wave_err++;
      end else if (load_len != 0) begin
         if (load_len != 4) wave_err++;
         load_cnt++;
         load_len = 0;
      end
      prev_sclk = bus_a.serial_clock;
      prev_sdo  = bus_a.serial_data_out;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done_a(output int n);
      n = 0;
      while (bus_a.done !== 1'b1 && n < 5000) begin
         @(negedge clock);
         n++;
      end
   endtask

   task automatic pulse_start_a();
      @(negedge clock) bus_a.start = 1'b1;
      @(negedge clock) bus_a.start = 1'b0;
   endtask

   task automatic check_pads(input string tag, input int pattern);
      int bad;
      logic [12:0] exp;
      bad = 0;
      for (int i = 0; i < 38; i++) begin
         exp = (pattern == 0) ? (13'h1000 | 13'(i)) : (13'h0800 | 13'(i << 4) | 13'h00A);
         if (pad_a[i*13 +: 13] !== exp) bad++;
      end
      chk(tag, 64'(bad), 64'd0);
   endtask

   int n, base, lc, k;

   initial begin
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      for (int i = 0; i < 64; i++) cfg_a[i] = 13'h1000 | 13'(i);
      cfg_b[1] = 3'b101;
      cfg_b[0] = 3'b011;

      repeat (3) @(negedge clock);
      chk("rst_busy",  {63'd0, bus_a.busy}, 64'd0);
      chk("rst_done",  {63'd0, bus_a.done}, 64'd0);
      chk("rst_sclk",  {63'd0, bus_a.serial_clock}, 64'd0);
      chk("rst_sdo",   {63'd0, bus_a.serial_data_out}, 64'd0);
      chk("rst_sload", {63'd0, bus_a.serial_load}, 64'd0);
      chk("rst_idx",   64'(bus_a.cfg_rd_idx), 64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // small instance: 2 pads x 3 bits, CLK_DIV=1
      bus_b.start = 1'b1;
      @(negedge clock) bus_b.start = 1'b0;
      chk("b_busy", {63'd0, bus_b.busy}, 64'd1);
      n = 0;
      while (bus_b.done !== 1'b1 && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk("b_latency", 64'(n), 64'd15);
      chk("b_busy_at_done", {63'd0, bus_b.busy}, 64'd0);
      chk("b_rises", 64'(rise_b), 64'd6);
      chk("b_bits", {58'd0, rec_b}, 64'b101011);
      chk("b_load_cycles", 64'(load_cyc_b), 64'd1);

      // default instance: single load
      pulse_start_a();
      chk("a_busy", {63'd0, bus_a.busy}, 64'd1);
      wait_done_a(n);
      chk("a_latency", 64'(n), 64'd3994);
      repeat (3) @(negedge clock);
      check_pads("a_pads1", 0);
      chk("a_pad0", {51'd0, pad_a[12:0]}, 64'h1000);
      chk("a_pad37", {51'd0, pad_a[37*13 +: 13]}, 64'h1025);
      chk("a_loads1", 64'(load_cnt), 64'd1);

      // start pulses during busy and during DONE are ignored
      pulse_start_a();
      repeat (200) @(negedge clock);
      bus_a.start = 1'b1;
      @(negedge clock) bus_a.start = 1'b0;
      wait_done_a(n);
      chk("a_latency_ign", 64'(n), 64'd3994 - 64'd201);
      bus_a.start = 1'b1;
      @(negedge clock) bus_a.start = 1'b0;
      repeat (20) @(negedge clock);
      chk("a_idle_after_ign", {63'd0, bus_a.busy}, 64'd0);
      chk("a_loads2", 64'(load_cnt), 64'd2);

      // start held high: back-to-back runs with one IDLE cycle between
      @(negedge clock) bus_a.start = 1'b1;
      wait_done_a(n);
      chk("a_latency_held", 64'(n), 64'd3995);
      @(negedge clock);
      chk("a_gap_idle", {63'd0, bus_a.busy}, 64'd0);
      @(negedge clock);
      chk("a_rerun_busy", {63'd0, bus_a.busy}, 64'd1);
      bus_a.start = 1'b0;
      wait_done_a(n);
      chk("a_latency_2nd", 64'(n), 64'd3994);
      repeat (3) @(negedge clock);
      chk("a_loads4", 64'(load_cnt), 64'd4);

      // reset at the 100th serial_clock rise of a load with new config
      for (int i = 0; i < 38; i++) cfg_a[i] = 13'h0800 | 13'(i << 4) | 13'h00A;
      snap_a = pad_a;
      lc = load_cnt;
      base = rise_a;
      pulse_start_a();
      k = 0;
      while (rise_a < base + 100 && k < 5000) begin
         @(posedge clock);
         #1;
         k++;
      end
      chk("a_rise100_reached", 64'(rise_a - base), 64'd100);
      reset = 1'b1;
      #1;
      chk("rst_mid_busy",  {63'd0, bus_a.busy}, 64'd0);
      chk("rst_mid_sclk",  {63'd0, bus_a.serial_clock}, 64'd0);
      chk("rst_mid_sdo",   {63'd0, bus_a.serial_data_out}, 64'd0);
      chk("rst_mid_sload", {63'd0, bus_a.serial_load}, 64'd0);
      chk("rst_mid_idx",   64'(bus_a.cfg_rd_idx), 64'd0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (10) @(negedge clock);
      chk("rst_no_load", 64'(load_cnt), 64'(lc));
      chk("rst_pads_kept", {63'd0, pad_a === snap_a}, 64'd1);

      pulse_start_a();
      wait_done_a(n);
      chk("a_latency_post_rst", 64'(n), 64'd3994);
      repeat (3) @(negedge clock);
      check_pads("a_pads2", 1);
      chk("a_loads_post_rst", 64'(load_cnt), 64'(lc + 1));
      chk("a_waveform", 64'(wave_err), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
